unary_add_ctrl: RTL and testbench

//  Sequencer wrapped around the 16-bit unary adder (A/B/en/read_or_write in, dout/C out).

---
 rtl/unary_add_ctrl.sv | 105 ++++++++++
 tb/tb_unary_add_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/unary_add_ctrl.sv
// Sequencer around the 16-bit unary adder: binary operands in, unary feed/drain, binary sum out.
// Build option: define UNARY_ADD_CTRL_SAT_EN to saturate the reported sum on overflow.
module unary_add_ctrl #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_val,
   input  logic [W-1:0] b_val,
   output logic         add_a,
   output logic         add_b,
   output logic         add_en,
   output logic         add_rw,
   input  logic         add_dout,
   input  logic         add_c,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         ovf
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FEED  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]   state;
   logic [W-1:0] ca, cb, cnt;
   logic [W-1:0] ca_nxt, cb_nxt;
   logic         first;
   logic         live;

   always_comb begin
      ca_nxt = (ca != '0) ? ca - W'(1) : ca;
      cb_nxt = (cb != '0) ? cb - W'(1) : cb;
   end

   // first marks the opening cycle of FEED (stale add_c) and of DRAIN (d0, stale add_dout)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         live  <= 1'b0;
         ca    <= '0;
         cb    <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         first <= 1'b0;
      end else begin
         live <= 1'b1;
         case (state)
            S_IDLE: begin
               if (live && in_valid) begin
                  ca    <= a_val;
                  cb    <= b_val;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  first <= 1'b1;
                  state <= ((a_val | b_val) != '0) ? S_FEED : S_DRAIN;
               end
            end
            S_FEED: begin
               ca    <= ca_nxt;
               cb    <= cb_nxt;
               first <= 1'b0;
               if (!first) ovf <= ovf | add_c;
               if (ca_nxt == '0 && cb_nxt == '0) begin
                  state <= S_DRAIN;
                  first <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (first) begin
                  first <= 1'b0;
                  ovf   <= ovf | add_c;
               end else if (add_dout) begin
                  cnt <= cnt + W'(1);
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == S_IDLE) && live;
      add_en    = (state == S_FEED) || (state == S_DRAIN);
      add_rw    = (state == S_DRAIN);
      add_a     = (state == S_FEED) && (ca != '0);
      add_b     = (state == S_FEED) && (cb != '0);
      out_valid = (state == S_DONE);
`ifdef UNARY_ADD_CTRL_SAT_EN
      sum       = ((state == S_DONE) && ovf) ? '1 : cnt;
`else
      sum       = cnt;
`endif
   end

endmodule

// File: tb/tb_unary_add_ctrl.sv
// Bench for unary_add_ctrl: behavioural unary adder plus directed and random operand pairs.
module tb_unary_add_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_val, b_val;
   logic        add_a, add_b, add_en, add_rw;
   logic        add_dout, add_c;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        ovf;

   int vectors = 0;
   int miscompares = 0;

   unary_add_ctrl #(.W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_val(a_val), .b_val(b_val),
      .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_rw(add_rw),
      .add_dout(add_dout), .add_c(add_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Unary adder: a count of pulses; carry per feed cycle, one dout pulse per drained unit
   int   acnt;
   logic mdout, mc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acnt  <= 0;
         mdout <= 1'b0;
         mc    <= 1'b0;
      end else if (add_en && !add_rw) begin
         acnt  <= (acnt + int'(add_a) + int'(add_b)) % 65536;
         mc    <= (acnt + int'(add_a) + int'(add_b)) >= 65536;
         mdout <= 1'b0;
      end else if (add_en) begin
         mdout <= (acnt != 0);
         if (acnt != 0) acnt <= acnt - 1;
      end else begin
         mdout <= 1'b0;
      end
   end
   assign add_dout = mdout;
   assign add_c    = mc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input int a, input int b, input int hold, input bit junk);
      int n, na, nb, nf, m, s, lat, esum;
      bit rbad, eovf;
      m    = (a > b) ? a : b;
      s    = (a + b) % 65536;
      eovf = (a + b) >= 65536;
      esum = s;
`ifdef UNARY_ADD_CTRL_SAT_EN
      if (eovf) esum = 65535;
`endif
      lat = m + s + 3;
      n = 0;
      while (!in_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_idle", 32'(in_ready), 32'd1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      a_val     = a[15:0];
      b_val     = b[15:0];
      @(negedge clk);
      n = 1; na = 0; nb = 0; nf = 0; rbad = 1'b0;
      if (junk) begin
         a_val = 16'($urandom);
         b_val = 16'($urandom);
      end else begin
         in_valid = 1'b0;
      end
      while (!out_valid && n < lat + 16) begin
         if (add_a) na++;
         if (add_b) nb++;
         if (add_en && !add_rw) nf++;
         if (in_ready) rbad = 1'b1;
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("out_valid", 32'(out_valid), 32'd1);
      check("latency", 32'(n), 32'(lat));
      check("sum", 32'(sum), 32'(esum));
      check("ovf", 32'(ovf), 32'(eovf));
      check("a_pulses", 32'(na), 32'(a));
      check("b_pulses", 32'(nb), 32'(b));
      check("feed_cycles", 32'(nf), 32'(m));
      check("busy_in_ready", 32'(rbad), 32'd0);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(esum));
            check("hold_in_ready", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_val     = '0;
      b_val     = '0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", 32'({in_ready, add_a, add_b, add_en, add_rw, out_valid, ovf}), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      rst_n = 1'b1;

      run_op(3, 5, 0, 1'b0);
      run_op(0, 0, 0, 1'b0);
      run_op(2, 2, 10, 1'b0);
      // carry on the very last feed cycle, then an op that must ignore the stale carry
      run_op(32768, 32768, 0, 1'b0);
      run_op(3, 5, 0, 1'b0);
      run_op(40000, 30000, 0, 1'b0);
      run_op(0, 7, 0, 1'b1);

      for (int i = 0; i < 12; i++)
         run_op(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      // abort mid-FEED
      in_valid = 1'b1;
      a_val    = 16'd100;
      b_val    = 16'd50;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("pre_abort_feed", 32'({add_en, add_rw}), 32'b10);
      rst_n = 1'b0;
      #1;
      check("abort_ctrl", 32'({in_ready, add_a, add_b, add_en, add_rw, out_valid, ovf}), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, 1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
